// File: rtl/cdc_pkg.sv
// Shared types and constants for the request/acknowledge clock-domain crossing.
package cdc_pkg;

  // Source-side handshake controller states.
  typedef enum logic [1:0] {
    StIdle,
    StWaitHi,
    StWaitLo,
    StRecover
  } state_t;

  // Legal depth range for the single-bit synchroniser.
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Width of a timer that must hold the values 0..cycles, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchroniser with asynchronous active-low reset.
module sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : gen_bad_stages
    $error("sync_bit: STAGES must be in the range 2..4");
  end

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; the first flop may go metastable.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_req_ack_src.sv
// Source-side controller of a four-phase req/ack crossing: accepts one word per valid/ready
// handshake, holds it while req is high, and reports completion or timeout.
module cdc_req_ack_src
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_a,
  input  logic                  reset_in,
  input  logic                  vld_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rdy_out,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  done_out,
  output logic                  timeout_out,
  output logic                  busy_out
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : gen_bad_stages
    $error("cdc_req_ack_src: SYNC_STAGES must be in the range 2..4");
  end

  localparam int unsigned TIMER_WIDTH = timer_width(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Last timer value before abort; irrelevant (and held at 0) when the timeout is disabled.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
      TIMEOUT_EN ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] timer_next;
  logic                   ack_s;
  logic                   expired;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk_a),
    .reset_in (reset_in),
    .d        (ack_in),
    .q        (ack_s)
  );

  // Saturating increment; the timer stays at 0 when the timeout is disabled.
  assign timer_next = (TIMEOUT_EN && (timer != TIMER_MAX)) ? timer + TIMER_WIDTH'(1) : timer;
  assign expired    = TIMEOUT_EN && (timer == TIMER_LAST);

  // Both decoded from registers only: no combinational path from vld_in.
  assign rdy_out  = (state == StIdle) && !ack_s;
  assign busy_out = (state != StIdle);

  // Handshake FSM with registered req, data and one-cycle status pulses.
  always_ff @(posedge clk_a or negedge reset_in) begin
    if (!reset_in) begin
      state       <= StIdle;
      timer       <= '0;
      req_out     <= 1'b0;
      data_out    <= '0;
      done_out    <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      done_out    <= 1'b0;
      timeout_out <= 1'b0;
      unique case (state)
        StIdle: begin
          // A stale ack from an aborted transfer blocks acceptance until it clears.
          if (vld_in && !ack_s) begin
            data_out <= data_in;
            req_out  <= 1'b1;
            timer    <= '0;
            state    <= StWaitHi;
          end
        end
        StWaitHi: begin
          // The exit condition takes priority over a coincident expiry.
          if (ack_s) begin
            req_out <= 1'b0;
            timer   <= '0;
            state   <= StWaitLo;
          end else if (expired) begin
            timeout_out <= 1'b1;
            req_out     <= 1'b0;
            state       <= StRecover;
          end else begin
            timer <= timer_next;
          end
        end
        StWaitLo: begin
          if (!ack_s) begin
            done_out <= 1'b1;
            state    <= StIdle;
          end else if (expired) begin
            timeout_out <= 1'b1;
            req_out     <= 1'b0;
            state       <= StRecover;
          end else begin
            timer <= timer_next;
          end
        end
        StRecover: begin
          req_out <= 1'b0;
          if (!ack_s) begin
            state <= StIdle;
          end
        end
        default: begin
          req_out <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_ack_src.sv
// Self-checking bench for cdc_req_ack_src: directed scenarios plus randomized transfers,
// with expected event times computed from the handshake latency rules.
module tb_cdc_req_ack_src;

  localparam int unsigned DW = 8;
  localparam int          S  = 2;
  localparam int          T  = 16;

  logic          clk_a    = 1'b0;
  logic          reset_in = 1'b0;
  logic          vld_in   = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic          ack_in   = 1'b0;
  logic          rdy_out;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          done_out;
  logic          timeout_out;
  logic          busy_out;

  always #5 clk_a = ~clk_a;

  cdc_req_ack_src #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_a       (clk_a),
    .reset_in    (reset_in),
    .vld_in      (vld_in),
    .data_in     (data_in),
    .rdy_out     (rdy_out),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .done_out    (done_out),
    .timeout_out (timeout_out),
    .busy_out    (busy_out)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n        = 0;   // edge counter
  int            done_edges[$];
  int            to_edges[$];
  int            fall_edge = -1;
  bit            prev_req  = 1'b0;
  logic [DW-1:0] model_data = '0;
  logic [DW-1:0] pending    = '0;
  int            glitches   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then observe: log pulses, req fall, and data_out against the model word.
  task automatic tick();
    @(posedge clk_a);
    #1;
    n++;
    if (!prev_req && req_out) model_data = pending;
    if (prev_req && !req_out) fall_edge = n;
    prev_req = req_out;
    if (done_out) done_edges.push_back(n);
    if (timeout_out) to_edges.push_back(n);
    if (data_out !== model_data) glitches++;
  endtask

  // One transfer as seen from the destination side: ack rises d_hi edges after req rises and
  // falls d_lo edges after req falls (or never rises at all).
  task automatic transfer(input logic [DW-1:0] w, input bit never_hi, input int d_hi,
                          input int d_lo, input bit junk);
    int k, exp_f, exp_idle, exp_done, exp_to, waited;
    bit want_done, want_to, rdy_bad;
    done_edges.delete();
    to_edges.delete();
    want_done = 1'b0;
    want_to   = 1'b0;
    exp_done  = 0;
    exp_to    = 0;
    rdy_bad   = 1'b0;
    check("rdy_before_accept", rdy_out, 1);
    vld_in  = 1'b1;
    data_in = w;
    pending = w;
    tick();
    k = n;
    check("req_after_accept", req_out, 1);
    check("busy_after_accept", busy_out, 1);
    check("rdy_after_accept", rdy_out, 0);
    check("data_captured", data_out, w);
    if (junk) data_in = 8'h3C;
    else vld_in = 1'b0;
    if (never_hi) begin
      for (int i = 0; i < 2; i++) tick();
      vld_in  = 1'b0;
      exp_f   = k + T;
      want_to = 1'b1;
      exp_to  = k + T;
      exp_idle = k + T + 1;
    end else begin
      for (int i = 0; i < d_hi; i++) tick();
      ack_in = 1'b1;
      vld_in = 1'b0;
      exp_f  = k + d_hi + 1 + S;
    end
    waited = 0;
    while (req_out && waited < 40) begin
      tick();
      waited++;
    end
    check("req_fall_seen", req_out, 0);
    check("req_fall_edge", fall_edge, exp_f);
    if (!never_hi) begin
      for (int i = 0; i < d_lo; i++) tick();
      ack_in   = 1'b0;
      exp_idle = fall_edge + d_lo + 1 + S;
      if (d_lo + 1 + S <= T) begin
        want_done = 1'b1;
        exp_done  = exp_idle;
      end else begin
        want_to = 1'b1;
        exp_to  = fall_edge + T;
      end
    end
    waited = 0;
    while (busy_out && waited < 60) begin
      if (to_edges.size() > 0 && rdy_out) rdy_bad = 1'b1;
      tick();
      waited++;
    end
    check("idle_reached", busy_out, 0);
    check("idle_edge", n, exp_idle);
    check("rdy_in_idle", rdy_out, 1);
    check("rdy_low_in_recover", rdy_bad, 0);
    check("done_count", done_edges.size(), want_done ? 1 : 0);
    check("timeout_count", to_edges.size(), want_to ? 1 : 0);
    if (want_done && done_edges.size() == 1) check("done_edge", done_edges[0], exp_done);
    if (want_to && to_edges.size() == 1) check("timeout_edge", to_edges[0], exp_to);
    check("data_held", data_out, w);
    check("data_stable", glitches, 0);
  endtask

  initial begin
    logic [DW-1:0] w;
    bit nh, jk;
    int dh, dl, gap;

    // Reset state
    #12;
    check("rst_rdy", rdy_out, 1);
    check("rst_req", req_out, 0);
    check("rst_data", data_out, 0);
    check("rst_done", done_out, 0);
    check("rst_timeout", timeout_out, 0);
    check("rst_busy", busy_out, 0);
    @(posedge clk_a);
    #1;
    reset_in = 1'b1;
    tick();
    tick();

    // Basic transfer, never-ack timeout, ack stuck high past the WAIT_LO timeout
    transfer(8'hA5, 1'b0, 3, 3, 1'b0);
    transfer(8'h5A, 1'b1, 0, 0, 1'b0);
    transfer(8'hC3, 1'b0, 2, 16, 1'b0);
    // Exit condition coincides with expiry in both phases; first timing-out WAIT_LO delay
    transfer(8'h11, 1'b0, 13, 13, 1'b0);
    transfer(8'h22, 1'b0, 0, 14, 1'b0);
    // Valid held with another word while busy
    transfer(8'h96, 1'b0, 5, 2, 1'b1);

    // Spurious ack in idle blocks acceptance
    ack_in = 1'b1;
    for (int i = 0; i < S + 1; i++) tick();
    check("spurious_rdy", rdy_out, 0);
    vld_in  = 1'b1;
    data_in = 8'h3C;
    tick();
    tick();
    check("spurious_req", req_out, 0);
    check("spurious_busy", busy_out, 0);
    check("spurious_data", data_out, 8'h96);
    vld_in = 1'b0;
    ack_in = 1'b0;
    for (int i = 0; i < S + 1; i++) tick();
    check("spurious_rdy_back", rdy_out, 1);

    // Asynchronous reset in the middle of WAIT_HI
    done_edges.delete();
    to_edges.delete();
    vld_in  = 1'b1;
    data_in = 8'h77;
    pending = 8'h77;
    tick();
    vld_in = 1'b0;
    check("pre_reset_req", req_out, 1);
    tick();
    tick();
    reset_in = 1'b0;
    #1;
    check("mid_reset_req", req_out, 0);
    check("mid_reset_busy", busy_out, 0);
    check("mid_reset_data", data_out, 0);
    model_data = '0;
    prev_req   = 1'b0;
    #1;
    reset_in = 1'b1;
    tick();
    tick();
    check("post_reset_rdy", rdy_out, 1);
    check("post_reset_pulses", done_edges.size() + to_edges.size(), 0);

    // Back-to-back transfers, each accepted in the previous done cycle
    for (int i = 1; i <= 4; i++) transfer(8'(i), 1'b0, 0, 0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      w   = 8'($urandom);
      nh  = ($urandom_range(0, 5) == 0);
      dh  = $urandom_range(0, 13);
      dl  = $urandom_range(0, 16);
      jk  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      transfer(w, nh, dh, dl, jk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
